gpio_in_reader: RTL and testbench

//  Input-side GPIO peripheral for the DLX on the DE2-115: the reader counterpart of the

---
 rtl/gpio_in_reader.sv | 98 +++++++++
 tb/tb_gpio_in_reader.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/gpio_in_reader.sv
// GPIO input reader: synchronises and debounces the board pins, latches edge events,
// and returns level/event words over a single-cycle read port.
module gpio_in_reader #(
   parameter int DATA_WIDTH      = 32,
   parameter int IN_WIDTH        = 21,
   parameter int DEBOUNCE_CYCLES = 10000,
   parameter int CNT_WIDTH       = 14
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [IN_WIDTH-1:0]   pins_in,
   input  logic                  rd_en,
   input  logic [1:0]            addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  irq
);

   logic [IN_WIDTH-1:0]   sync1_q, sync2_q;
   logic [IN_WIDTH-1:0]   h0_q, h0_d, h1_q, h1_d;
   logic [IN_WIDTH-1:0]   level_q, level_d;
   logic [IN_WIDTH-1:0]   rise_q, rise_d, fall_q, fall_d;
   logic [IN_WIDTH-1:0]   stable, rise_set, fall_set, sel;
   logic [CNT_WIDTH-1:0]  presc_q, presc_d;
   logic [1:0]            prime_q, prime_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d, rd_word;
   logic                  rd_valid_q, irq_q, irq_d;
   logic                  tick, primed, clr_rise, clr_fall;

   always_comb begin
      tick    = (presc_q == CNT_WIDTH'(DEBOUNCE_CYCLES - 1));
      presc_d = tick ? '0 : presc_q + CNT_WIDTH'(1);
      primed  = (prime_q == 2'd3);
      stable  = ~(sync2_q ^ h0_q) & ~(h0_q ^ h1_q);
      h0_d    = h0_q;
      h1_d    = h1_q;
      level_d = level_q;
      prime_d = prime_q;
      if (tick) begin
         h0_d    = sync2_q;
         h1_d    = h0_q;
         level_d = (stable & sync2_q) | (~stable & level_q);
         if (!primed) prime_d = prime_q + 2'd1;
      end
      // events only after three ticks so pins held at reset stay quiet
      rise_set = (tick && primed) ? (level_d & ~level_q) : '0;
      fall_set = (tick && primed) ? (~level_d & level_q) : '0;
      clr_rise = rd_en && (addr == 2'd1);
      clr_fall = rd_en && (addr == 2'd2);
      rise_d   = (clr_rise ? '0 : rise_q) | rise_set;
      fall_d   = (clr_fall ? '0 : fall_q) | fall_set;
      irq_d    = (|rise_d) | (|fall_d);
      case (addr)
         2'd0:    sel = level_q;
         2'd1:    sel = rise_q;
         2'd2:    sel = fall_q;
         default: sel = sync2_q;
      endcase
      rd_word                = '0;
      rd_word[IN_WIDTH-1:0]  = sel;
      rd_data_d = rd_en ? rd_word : rd_data_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         h0_q       <= '0;
         h1_q       <= '0;
         level_q    <= '0;
         rise_q     <= '0;
         fall_q     <= '0;
         presc_q    <= '0;
         prime_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         sync1_q    <= pins_in;
         sync2_q    <= sync1_q;
         h0_q       <= h0_d;
         h1_q       <= h1_d;
         level_q    <= level_d;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
         presc_q    <= presc_d;
         prime_q    <= prime_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_en;
         irq_q      <= irq_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_in_reader.sv
// Bench for gpio_in_reader: level/event table plus timed corner-case sequences,
// with read results checked from a scoreboard queue.
module tb_gpio_in_reader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [20:0] pins_in = 21'h1FFFFF;
   logic        rd_en = 1'b0;
   logic [1:0]  addr = 2'd0;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        irq;

   int total = 0;
   int bad = 0;
   int cyc;
   logic [31:0] exp_q[$];

   typedef struct {
      logic [20:0] pins;
      logic [31:0] lvl;
      logic [31:0] rise;
      logic [31:0] fall;
   } vec_t;
   vec_t tbl[5];

   gpio_in_reader #(
      .DATA_WIDTH(32), .IN_WIDTH(21),
      .DEBOUNCE_CYCLES(4), .CNT_WIDTH(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pins_in(pins_in),
      .rd_en(rd_en), .addr(addr), .rd_data(rd_data),
      .rd_valid(rd_valid), .irq(irq)
   );

   always #5 clk = ~clk;

   // edge number since reset release; tick edges are multiples of 4
   always @(posedge clk or negedge rst_n)
      if (!rst_n) cyc <= 0;
      else cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && rd_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_valid: got rd_valid=1 expected no read");
         end else begin
            chk("read_data", rd_data, exp_q.pop_front());
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] e);
      rd_en = 1'b1;
      addr  = a;
      exp_q.push_back(e);
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   initial begin
      int target;
      tbl[0] = '{21'h000000, 32'h000000, 32'h000000, 32'h1FFFFF};
      tbl[1] = '{21'h000001, 32'h000001, 32'h000001, 32'h000000};
      tbl[2] = '{21'h0AAAAA, 32'h0AAAAA, 32'h0AAAAA, 32'h000001};
      tbl[3] = '{21'h155555, 32'h155555, 32'h155555, 32'h0AAAAA};
      tbl[4] = '{21'h1F0F0F, 32'h1F0F0F, 32'h0A0A0A, 32'h005050};

      // T1: reset with all pins high
      #12;
      chk("rst_valid", {31'd0, rd_valid}, 32'd0);
      chk("rst_data", rd_data, 32'd0);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cycles(20);
      rd(2'd0, 32'h001FFFFF);
      rd(2'd1, 32'h0);
      rd(2'd2, 32'h0);
      rd(2'd3, 32'h001FFFFF);
      chk("t1_irq", {31'd0, irq}, 32'd0);

      for (int i = 0; i < 5; i++) begin
         pins_in = tbl[i].pins;
         cycles(20);
         rd(2'd0, tbl[i].lvl);
         rd(2'd1, tbl[i].rise);
         rd(2'd2, tbl[i].fall);
         chk("tbl_irq", {31'd0, irq}, 32'd0);
      end

      // T3: bounce on bit 5 never reaches the level
      for (int i = 0; i < 40; i++) begin
         if (i % 3 == 0) pins_in[5] = ~pins_in[5];
         @(negedge clk);
      end
      pins_in[5] = 1'b0;
      cycles(20);
      rd(2'd0, 32'h001F0F0F);
      rd(2'd1, 32'h0);
      rd(2'd2, 32'h0);

      // T5: fall on bit 20
      pins_in[20] = 1'b0;
      cycles(20);
      rd(2'd2, 32'h00100000);
      rd(2'd0, 32'h000F0F0F);
      rd(2'd1, 32'h0);

      // T2: clean rise on bit 0
      pins_in = '0;
      cycles(20);
      rd(2'd2, 32'h000F0F0F);
      chk("t2_irq_idle", {31'd0, irq}, 32'd0);
      pins_in[0] = 1'b1;
      cycles(20);
      chk("t2_irq_set", {31'd0, irq}, 32'd1);
      rd(2'd0, 32'h1);
      rd(2'd1, 32'h1);
      chk("t2_irq_clr", {31'd0, irq}, 32'd0);
      rd(2'd1, 32'h0);

      // T4: clear-on-read lands on the tick that sets bit 3
      pins_in[2] = 1'b1;
      cycles(20);
      chk("t4_irq", {31'd0, irq}, 32'd1);
      while (cyc % 4 != 0) @(negedge clk);
      pins_in[3] = 1'b1;
      target = cyc + 12;
      while (cyc < target - 1) @(negedge clk);
      rd(2'd1, 32'h4);
      rd(2'd1, 32'h8);
      chk("t4_irq_clr", {31'd0, irq}, 32'd0);

      // T6: async reset in the middle of a debounce
      pins_in[6] = 1'b1;
      cycles(20);
      chk("t6_irq_pre", {31'd0, irq}, 32'd1);
      pins_in[7] = 1'b1;
      cycles(5);
      rd_en = 1'b1;
      addr  = 2'd0;
      @(posedge clk);
      #1;
      rd_en = 1'b0;
      chk("t6_valid_pre", {31'd0, rd_valid}, 32'd1);
      chk("t6_data_pre", rd_data, 32'h0000004D);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_valid_rst", {31'd0, rd_valid}, 32'd0);
      chk("t6_data_rst", rd_data, 32'd0);
      chk("t6_irq_rst", {31'd0, irq}, 32'd0);
      cycles(2);
      rst_n = 1'b1;
      cycles(20);
      chk("t6_irq_prime", {31'd0, irq}, 32'd0);
      rd(2'd0, 32'h000000CD);
      rd(2'd1, 32'h0);
      rd(2'd2, 32'h0);
      pins_in[9] = 1'b1;
      cycles(20);
      rd(2'd1, 32'h00000200);
      rd(2'd0, 32'h000002CD);

      cycles(3);
      chk("queue_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
